// File: rtl/ascon_aead128_host_ctrl.sv
// Host-side sequencer for ascon_aead128_core: takes one AEAD job descriptor, streams AD/data
// blocks into the core, buffers output blocks and checks the decryption tag.
module ascon_aead128_host_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic             job_op_mode,
    input  logic [127:0]     job_key,
    input  logic [127:0]     job_nonce,
    input  logic [127:0]     job_tag,
    input  logic [CNT_W-1:0] job_n_ad,
    input  logic [CNT_W-1:0] job_n_db,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             core_start,
    output logic             core_op_mode,
    output logic             core_valid_ad,
    output logic             core_valid_db_in,
    output logic [127:0]     core_ad,
    output logic [127:0]     core_db,
    output logic [127:0]     core_key,
    output logic [127:0]     core_nonce,
    input  logic             core_ready,
    input  logic             core_valid_db_out,
    input  logic             core_valid_tag,
    input  logic [127:0]     core_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             done,
    output logic [127:0]     tag_data,
    output logic             auth_ok
);

    typedef enum logic [2:0] {IDLE, AD, DB, WAIT_OUT, WAIT_TAG} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             op_mode_q;
    logic [127:0]     key_q, nonce_q, tag_q;
    logic [CNT_W-1:0] n_ad_q, n_db_q, ad_cnt_q, db_cnt_q;
    logic             buf_valid_q;
    logic [127:0]     buf_data_q, tag_data_q;
    logic             auth_ok_q, done_q;
    logic             accept, ad_xfer, db_xfer, last_db, last_ad, db_out_ev, tag_ev;

    assign accept    = (state_q == IDLE) && job_valid;
    assign last_ad   = (ad_cnt_q == n_ad_q - ONE);
    assign last_db   = (db_cnt_q == n_db_q - ONE);
    assign ad_xfer   = (state_q == AD) && in_valid && core_ready;
    // DB stalls while the output buffer is still occupied so it is never overwritten
    assign db_xfer   = (state_q == DB) && in_valid && core_ready && !buf_valid_q;
    assign db_out_ev = (state_q == WAIT_OUT) && core_valid_db_out;
    assign tag_ev    = (state_q == WAIT_TAG) && core_valid_tag;

    always_comb begin
        state_d          = state_q;
        job_ready        = 1'b0;
        in_ready         = 1'b0;
        core_start       = 1'b0;
        core_valid_ad    = 1'b0;
        core_valid_db_in = 1'b0;
        core_ad          = '0;
        core_db          = '0;
        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_d = (job_n_ad != '0) ? AD : DB;
            end
            AD: begin
                core_start    = 1'b1;
                core_ad       = in_data;
                core_db       = in_data;
                core_valid_ad = in_valid;
                in_ready      = core_ready;
                if (ad_xfer && last_ad) state_d = DB;
            end
            DB: begin
                core_start       = !last_db;
                core_ad          = in_data;
                core_db          = in_data;
                core_valid_db_in = in_valid && !buf_valid_q;
                in_ready         = core_ready && !buf_valid_q;
                if (db_xfer) state_d = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (core_valid_db_out) state_d = last_db ? WAIT_TAG : DB;
            end
            WAIT_TAG: begin
                if (core_valid_tag) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_mode_q   <= 1'b0;
            key_q       <= '0;
            nonce_q     <= '0;
            tag_q       <= '0;
            n_ad_q      <= '0;
            n_db_q      <= '0;
            ad_cnt_q    <= '0;
            db_cnt_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            tag_data_q  <= '0;
            auth_ok_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                op_mode_q  <= job_op_mode;
                key_q      <= job_key;
                nonce_q    <= job_nonce;
                tag_q      <= job_tag;
                n_ad_q     <= job_n_ad;
                n_db_q     <= (job_n_db == '0) ? ONE : job_n_db;
                ad_cnt_q   <= '0;
                db_cnt_q   <= '0;
                tag_data_q <= '0;
                auth_ok_q  <= 1'b0;
            end
            if (ad_xfer) ad_cnt_q <= ad_cnt_q + ONE;
            if (db_out_ev) begin
                buf_valid_q <= 1'b1;
                buf_data_q  <= core_dout;
                db_cnt_q    <= db_cnt_q + ONE;
            end else if (buf_valid_q && out_ready) begin
                buf_valid_q <= 1'b0;
            end
            if (tag_ev) begin
                tag_data_q <= core_dout;
                auth_ok_q  <= op_mode_q ? (core_dout == tag_q) : 1'b1;
                done_q     <= 1'b1;
            end
        end
    end

    assign core_op_mode = op_mode_q;
    assign core_key     = key_q;
    assign core_nonce   = nonce_q;
    assign out_valid    = buf_valid_q;
    assign out_data     = buf_data_q;
    assign done         = done_q;
    assign tag_data     = tag_data_q;
    assign auth_ok      = auth_ok_q;

endmodule

// File: tb/tb_ascon_aead128_host_ctrl.sv
// Scoreboard bench for ascon_aead128_host_ctrl with a behavioural core: out = db ^ key,
// tag = key ^ nonce ^ op_mode.
module tb_ascon_aead128_host_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             job_valid, job_ready, job_op_mode;
    logic [127:0]     job_key, job_nonce, job_tag;
    logic [CNT_W-1:0] job_n_ad, job_n_db;
    logic             in_valid, in_ready;
    logic [127:0]     in_data;
    logic             core_start, core_op_mode, core_valid_ad, core_valid_db_in;
    logic [127:0]     core_ad, core_db, core_key, core_nonce;
    logic             core_ready, core_valid_db_out, core_valid_tag;
    logic [127:0]     core_dout;
    logic             out_valid, out_ready;
    logic [127:0]     out_data;
    logic             done;
    logic [127:0]     tag_data;
    logic             auth_ok;

    always #5 clk = ~clk;

    ascon_aead128_host_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_op_mode(job_op_mode),
        .job_key(job_key), .job_nonce(job_nonce), .job_tag(job_tag),
        .job_n_ad(job_n_ad), .job_n_db(job_n_db),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_start(core_start), .core_op_mode(core_op_mode),
        .core_valid_ad(core_valid_ad), .core_valid_db_in(core_valid_db_in),
        .core_ad(core_ad), .core_db(core_db), .core_key(core_key), .core_nonce(core_nonce),
        .core_ready(core_ready), .core_valid_db_out(core_valid_db_out),
        .core_valid_tag(core_valid_tag), .core_dout(core_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .tag_data(tag_data), .auth_ok(auth_ok)
    );

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    int unsigned  done_seen = 0;
    logic [127:0] exp_out[$];
    logic         exp_start[$];
    logic [128:0] exp_done[$];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endfunction

    // Behavioural core: 3-cycle block latency, tag one cycle after the final output block
    logic         busy, last_blk, tag_pend;
    logic [1:0]   lat;
    logic [127:0] pend;
    assign core_ready = !busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0; last_blk <= 1'b0; tag_pend <= 1'b0; lat <= 2'd0; pend <= '0;
            core_valid_db_out <= 1'b0; core_valid_tag <= 1'b0; core_dout <= '0;
        end else begin
            core_valid_db_out <= 1'b0;
            core_valid_tag    <= 1'b0;
            if (tag_pend) begin
                core_valid_tag <= 1'b1;
                core_dout      <= core_key ^ core_nonce ^ {127'b0, core_op_mode};
                tag_pend       <= 1'b0;
            end else if (busy) begin
                if (lat == 2'd0) begin
                    core_valid_db_out <= 1'b1;
                    core_dout         <= pend;
                    busy              <= 1'b0;
                    tag_pend          <= last_blk;
                end else begin
                    lat <= lat - 2'd1;
                end
            end else if (core_valid_db_in) begin
                busy     <= 1'b1;
                lat      <= 2'd2;
                pend     <= core_db ^ core_key;
                last_blk <= !core_start;
            end
        end
    end

    // Monitor: compares core_start per transfer, output blocks and done results
    always @(negedge clk) begin
        if (rst_n) begin
            if ((core_valid_ad || core_valid_db_in) && core_ready) begin
                if (exp_start.size() == 0) fail_now("unexpected_core_transfer");
                else check1("core_start", core_start, exp_start.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) fail_now("unexpected_out_block");
                else check("out_data", out_data, exp_out.pop_front());
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    logic [128:0] e;
                    e = exp_done.pop_front();
                    check("tag_data", tag_data, e[127:0]);
                    check1("auth_ok", auth_ok, e[128]);
                end
            end
        end
    end

    task automatic issue(input logic op, input logic [127:0] key, input logic [127:0] nonce,
                         input logic [127:0] tag, input int n_ad, input int n_db);
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (job_ready) break;
        end
        if (t == 200) fail_now("job_ready_wait");
        job_op_mode = op; job_key = key; job_nonce = nonce; job_tag = tag;
        job_n_ad = CNT_W'(n_ad); job_n_db = CNT_W'(n_db);
        job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d);
        int t;
        in_data  = d;
        in_valid = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 300) fail_now("in_ready_wait");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_job(input logic op, input logic [127:0] key, input logic [127:0] nonce,
                           input logic [127:0] tag, input int n_ad, input int n_db,
                           input logic [127:0] base);
        int          ndb;
        int unsigned d0;
        int          t;
        logic [127:0] ref_tag;
        ndb     = (n_db == 0) ? 1 : n_db;
        d0      = done_seen;
        ref_tag = key ^ nonce ^ {127'b0, op};
        issue(op, key, nonce, tag, n_ad, n_db);
        for (int i = 0; i < n_ad; i++) exp_start.push_back(1'b1);
        for (int i = 0; i < ndb; i++) begin
            exp_start.push_back(i != ndb - 1);
            exp_out.push_back((base + 128'(n_ad + i)) ^ key);
        end
        exp_done.push_back({op ? (tag == ref_tag) : 1'b1, ref_tag});
        for (int i = 0; i < n_ad + ndb; i++) send_block(base + 128'(i));
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (done_seen != d0) break;
        end
        if (t == 500) fail_now("done_wait");
        repeat (4) @(negedge clk);
        check("out_blocks_left", 128'(exp_out.size()), 128'd0);
        check("done_count", 128'(done_seen - d0), 128'd1);
    endtask

    task automatic check_reset_values();
        check1("rst_job_ready", job_ready, 1'b1);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_core_start", core_start, 1'b0);
        check1("rst_core_valid_ad", core_valid_ad, 1'b0);
        check1("rst_core_valid_db_in", core_valid_db_in, 1'b0);
        check1("rst_core_op_mode", core_op_mode, 1'b0);
        check("rst_core_key", core_key, 128'd0);
        check("rst_core_nonce", core_nonce, 128'd0);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'd0);
        check1("rst_done", done, 1'b0);
        check1("rst_auth_ok", auth_ok, 1'b0);
        check("rst_tag_data", tag_data, 128'd0);
    endtask

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] N1 = 128'hf0e0d0c0b0a090807060504030201000;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] N2 = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        int viol;
        int t;
        job_valid = 1'b0; job_op_mode = 1'b0; job_key = '0; job_nonce = '0; job_tag = '0;
        job_n_ad = '0; job_n_db = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        rst_n = 1'b1;

        // encrypt, 1 AD + 1 DB
        run_job(1'b0, K1, N1, 128'd0, 1, 1, 128'h100);
        // decrypt, correct tag (key ^ nonce ^ 1)
        run_job(1'b1, K2, N2, K2 ^ N2 ^ 128'd1, 2, 3, 128'h200);
        // decrypt, tag bit 0 flipped
        run_job(1'b1, K2, N2, K2 ^ N2, 2, 3, 128'h300);
        // no AD, n_db = 0 treated as one block
        run_job(1'b0, N1, K1, 128'd0, 0, 0, 128'h400);

        // output backpressure for 20 cycles after the first block
        out_ready = 1'b0;
        viol = 0;
        fork
            run_job(1'b0, K2, N1, 128'd0, 1, 4, 128'h500);
            begin
                for (t = 0; t < 300; t++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                if (t == 300) fail_now("first_out_wait");
                repeat (20) begin
                    @(negedge clk);
                    if (in_ready || core_valid_db_in) viol++;
                end
                check("stall_violations", 128'(viol), 128'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // reset in the middle of a 4-block job with an output sitting in the buffer
        out_ready = 1'b0;
        issue(1'b0, K1, N2, 128'd0, 0, 4);
        exp_start.push_back(1'b1);
        send_block(128'h600);
        repeat (8) @(negedge clk);
        check1("pre_reset_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        exp_out.delete();
        exp_start.delete();
        exp_done.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        run_job(1'b1, K1, N2, K1 ^ N2 ^ 128'd1, 1, 2, 128'h700);

        repeat (5) @(negedge clk);
        check("start_queue_left", 128'(exp_start.size()), 128'd0);
        check("done_queue_left", 128'(exp_done.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
